sw_debounce: RTL and testbench
==============================

// Module: sw_debounce
// PURPOSE
//  Conditions the raw board slide switches before they reach the LED running-light
//  controller, which consumes the cleaned vector as its i_sw input.
//  Each bit passes through a synchroniser, then a stability counter; the output bit changes
//  only after the input has held its new level for DEBOUNCE_CYCLES consecutive clocks.
//  Also emits per-bit one-cycle rise/fall pulses and an any-change strobe for software or event logic.
// PARAMETERS
//  N_SW             8          number of switch channels
//  DEBOUNCE_CYCLES  1_000_000  consecutive stable clocks required (10 ms @ 100 MHz); legal range >= 1
//  SYNC_STAGES      2          synchroniser flop depth; legal range >= 2
// PORTS
//  s00_axi_aclk     in   1      system clock, shared with the AXI-Lite slave and LED logic
//  s00_axi_aresetn  in   1      reset, asynchronous assert, active-low
//  i_sw_raw         in   N_SW   raw asynchronous switch pins
//  o_sw             out  N_SW   debounced switch levels (drives LED controller i_sw)
//  o_sw_rise        out  N_SW   1-cycle pulse per bit when o_sw bit goes 0->1
//  o_sw_fall        out  N_SW   1-cycle pulse per bit when o_sw bit goes 1->0
//  o_sw_changed     out  1      1-cycle pulse, OR of all rise/fall bits
// BEHAVIOUR
//  - Reset (s00_axi_aresetn=0, asynchronous): all sync flops=0, counters=0, o_sw=0.
//    Rise, fall and changed outputs=0 while reset is asserted and on the first cycle after release.
//  - Sync: per bit, SYNC_STAGES-deep flop chain. sync_q is the last stage. No logic between stages.
//  - Per-bit counter cnt, width $clog2(DEBOUNCE_CYCLES+1). Every rising edge:
//      sync_q==o_sw                        -> cnt<=0
//      sync_q!=o_sw, cnt<DEBOUNCE_CYCLES-1 -> cnt<=cnt+1
//      sync_q!=o_sw, cnt==DEBOUNCE_CYCLES-1 -> o_sw<=sync_q, cnt<=0, rise/fall pulse<=1
//  - Latency: a raw level captured at edge 0 appears on o_sw after edge SYNC_STAGES+DEBOUNCE_CYCLES-1
//    (edge 5 for SYNC_STAGES=2, DEBOUNCE_CYCLES=4).
//  - Bounce: any sync_q sample equal to o_sw before terminal count clears cnt to 0, so counting restarts.
//    Pulses shorter than DEBOUNCE_CYCLES never reach o_sw.
//  - Pulses are registered, aligned with the o_sw update, and high for exactly 1 cycle.
//    o_sw_changed is registered in the same cycle as them.
//  - Channels are fully independent. Simultaneous terminal counts on several bits update all of
//    those bits in the same cycle, with one o_sw_changed pulse.
//  - DEBOUNCE_CYCLES=1: o_sw follows sync_q with 1 cycle of delay. The counter never increments.
//  - cnt never exceeds DEBOUNCE_CYCLES-1; no wrap-around path exists.
//  - Reset mid-count: cnt and o_sw return to 0 immediately. A switch still held high at release
//    re-qualifies after the full latency and produces a rise pulse.
// STRUCTURE
//  - Shared package sw_pkg: localparam N_SW_DEFAULT=8, DEBOUNCE_10MS_100MHZ=1_000_000,
//    and the function clog2 used for counter widths.
//  - Sub-module sw_debounce_bit (one channel: sync chain, counter, level, rise/fall).
//    sw_debounce instantiates it N_SW times with a generate loop and ORs the pulses into o_sw_changed.
// TESTING (bench uses DEBOUNCE_CYCLES=4, SYNC_STAGES=2, 10 ns clock)
//  1 Reset: hold aresetn=0 with i_sw_raw=8'hFF -> o_sw=8'h00 and no pulses.
//    Release -> o_sw=8'hFF at edge 5 after release, with o_sw_rise=8'hFF and o_sw_changed=1 for 1 cycle.
//  2 Clean step: i_sw_raw 8'h00->8'h02 before edge 0 -> o_sw=8'h02 after edge 5, o_sw_rise=8'h02 for 1 cycle;
//    return to 8'h00 -> o_sw_fall=8'h02 after 5 edges.
//  3 Bounce: bit0 toggles 1,0,1,1,0,1,1,1,1 every clock -> o_sw[0] rises only after the last four 1s
//    have been synchronised; no earlier pulse; exactly one rise.
//  4 Glitch: bit3 high for 3 cycles then low -> o_sw stays 8'h00 and all pulse outputs stay 0 throughout.
//  5 Simultaneous: bits 0 and 7 change in the same cycle -> both o_sw bits update on the same edge,
//    with o_sw_rise=8'h81 and a single o_sw_changed pulse.
//  6 Reset mid-count: assert aresetn at cnt=2 on bit1 -> o_sw[1]=0 immediately (asynchronous);
//    after release with bit1 still high -> o_sw[1]=1 at edge 5.

Source files
------------

// File: rtl/sw_pkg.sv
// rtl/sw_pkg.sv - shared constants and width helper for the switch debouncer
package sw_pkg;

    localparam int N_SW_DEFAULT         = 8;
    localparam int DEBOUNCE_10MS_100MHZ = 1_000_000;

    // Smallest r with 2**r >= value; always at least 1 so counters never collapse to zero width.
    function automatic int clog2(input int value);
        int r;
        r = 1;
        for (int i = 1; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/sw_debounce_bit.sv
// rtl/sw_debounce_bit.sv - one switch channel: synchroniser, stability counter, level and edge pulses
module sw_debounce_bit
    import sw_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sw_raw_i,
    output logic sw_o,
    output logic rise_o,
    output logic fall_o,
    output logic event_d_o
);

    localparam int                CNT_W    = clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync_bit;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync_bit = sync_q[SYNC_STAGES-1];

    // Any sample matching the current level restarts qualification from zero.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        rise_d  = 1'b0;
        fall_d  = 1'b0;
        if (sync_bit != level_q) begin
            if (cnt_q == CNT_TERM) begin
                level_d = sync_bit;
                rise_d  = sync_bit;
                fall_d  = ~sync_bit;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
        end else begin
            sync_q  <= {sync_q[SYNC_STAGES-2:0], sw_raw_i};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
        end
    end

    assign sw_o      = level_q;
    assign rise_o    = rise_q;
    assign fall_o    = fall_q;
    assign event_d_o = rise_d | fall_d;

endmodule

// File: rtl/sw_debounce.sv
// rtl/sw_debounce.sv - N_SW-channel switch debouncer with per-bit edge pulses and any-change strobe
module sw_debounce
    import sw_pkg::*;
#(
    parameter int N_SW            = N_SW_DEFAULT,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_10MS_100MHZ,
    parameter int SYNC_STAGES     = 2
) (
    input  logic            s00_axi_aclk,
    input  logic            s00_axi_aresetn,
    input  logic [N_SW-1:0] i_sw_raw,
    output logic [N_SW-1:0] o_sw,
    output logic [N_SW-1:0] o_sw_rise,
    output logic [N_SW-1:0] o_sw_fall,
    output logic            o_sw_changed
);

    logic [N_SW-1:0] event_d;
    logic            changed_q, changed_d;

    for (genvar g = 0; g < N_SW; g++) begin : g_bit
        sw_debounce_bit #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .SYNC_STAGES    (SYNC_STAGES)
        ) u_bit (
            .clk_i    (s00_axi_aclk),
            .rst_ni   (s00_axi_aresetn),
            .sw_raw_i (i_sw_raw[g]),
            .sw_o     (o_sw[g]),
            .rise_o   (o_sw_rise[g]),
            .fall_o   (o_sw_fall[g]),
            .event_d_o(event_d[g])
        );
    end

    // Registered from the channels' next-state pulses so the strobe lands with o_sw_rise/o_sw_fall.
    assign changed_d = |event_d;

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            changed_q <= 1'b0;
        end else begin
            changed_q <= changed_d;
        end
    end

    assign o_sw_changed = changed_q;

endmodule

// File: tb/tb_sw_debounce.sv
// tb/tb_sw_debounce.sv - scoreboard bench for sw_debounce with DEBOUNCE_CYCLES=4, SYNC_STAGES=2
module tb_sw_debounce;

    localparam int N_SW    = 8;
    localparam int LATENCY = 6;

    typedef struct {
        int         cyc;
        logic [7:0] sw;
        logic [7:0] rise;
        logic [7:0] fall;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] raw;
    logic [7:0] o_sw, o_rise, o_fall;
    logic       o_changed;

    int   cyc = 0;
    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];

    sw_debounce #(
        .N_SW           (N_SW),
        .DEBOUNCE_CYCLES(4),
        .SYNC_STAGES    (2)
    ) dut (
        .s00_axi_aclk   (clk),
        .s00_axi_aresetn(rst_n),
        .i_sw_raw       (raw),
        .o_sw           (o_sw),
        .o_sw_rise      (o_rise),
        .o_sw_fall      (o_fall),
        .o_sw_changed   (o_changed)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic expect_evt(input int at, input logic [7:0] sw, input logic [7:0] rise,
                              input logic [7:0] fall);
        exp_t e;
        e.cyc  = at;
        e.sw   = sw;
        e.rise = rise;
        e.fall = fall;
        exp_q.push_back(e);
    endtask

    // Drive raw at a falling edge; the following rising edge is "edge 0".
    task automatic drive(input logic [7:0] v);
        @(negedge clk);
        raw = v;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Monitor: every change strobe must match the head of the scoreboard, including its cycle.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (o_changed === 1'b1) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_event", {o_sw, o_rise, o_fall}, 24'h0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("event_cycle", cyc, e.cyc);
                    check("event_sw", o_sw, e.sw);
                    check("event_rise", o_rise, e.rise);
                    check("event_fall", o_fall, e.fall);
                end
            end else if ((o_rise | o_fall) != 8'h00) begin
                check("pulse_without_changed", {o_rise, o_fall}, 16'h0);
            end
        end
    end

    initial begin
        raw   = 8'hFF;
        rst_n = 1'b1;
        #2 rst_n = 1'b0;

        // 1: reset holds everything low even with all switches up
        repeat (3) begin
            @(negedge clk);
            check("reset_sw", o_sw, 8'h00);
            check("reset_pulses", {o_rise, o_fall, 7'h0, o_changed}, 24'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        expect_evt(cyc + LATENCY, 8'hFF, 8'hFF, 8'h00);
        @(negedge clk);
        check("first_cycle_after_release", {o_sw, o_rise, o_fall, 7'h0, o_changed}, 32'h0);
        idle(9);
        check("all_up_level", o_sw, 8'hFF);
        drive(8'h00);
        expect_evt(cyc + LATENCY, 8'h00, 8'h00, 8'hFF);
        idle(10);

        // 2: clean step on bit1
        drive(8'h02);
        expect_evt(cyc + LATENCY, 8'h02, 8'h02, 8'h00);
        idle(10);
        drive(8'h00);
        expect_evt(cyc + LATENCY, 8'h00, 8'h00, 8'h02);
        idle(10);

        // 3: bounce on bit0; only the trailing run of four 1s qualifies
        begin
            logic [8:0] pat;
            pat = 9'b1_1110_1101;
            for (int i = 0; i < 9; i++) begin
                drive({7'h0, pat[i]});
                if (i == 5) expect_evt(cyc + LATENCY, 8'h01, 8'h01, 8'h00);
            end
        end
        idle(10);
        drive(8'h00);
        expect_evt(cyc + LATENCY, 8'h00, 8'h00, 8'h01);
        idle(10);

        // 4: 3-cycle glitch on bit3 never reaches the output
        drive(8'h08);
        idle(2);
        drive(8'h00);
        idle(10);
        check("glitch_level", o_sw, 8'h00);

        // 5: simultaneous bits 0 and 7
        drive(8'h81);
        expect_evt(cyc + LATENCY, 8'h81, 8'h81, 8'h00);
        idle(10);
        drive(8'h00);
        expect_evt(cyc + LATENCY, 8'h00, 8'h00, 8'h81);
        idle(10);

        // 6: reset while bit1 is at cnt=2 and bit0 is already qualified high
        drive(8'h01);
        expect_evt(cyc + LATENCY, 8'h01, 8'h01, 8'h00);
        idle(10);
        drive(8'h03);
        repeat (4) @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("async_reset_sw", o_sw, 8'h00);
        check("async_reset_pulses", {o_rise, o_fall, 7'h0, o_changed}, 24'h0);
        idle(3);
        rst_n = 1'b1;
        expect_evt(cyc + LATENCY, 8'h03, 8'h03, 8'h00);
        idle(10);
        check("requalified_level", o_sw, 8'h03);
        drive(8'h00);
        expect_evt(cyc + LATENCY, 8'h00, 8'h00, 8'h03);
        idle(10);

        check("events_outstanding", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
